// File: rtl/sni_rx_deframer.sv
// SNI receive deframer: hunts the preamble/SFD, deserialises the body MSB-first into bytes
// for the RX FIFO (EOD on the last byte) and pulses per-frame status. Macro: SNI_RX_FCS_CHECK_EN.
module sni_rx_deframer #(
  parameter int MIN_PREAMBLE = 16,
  parameter int MIN_FRAME    = 64,
  parameter int MAX_FRAME    = 1518
) (
  input  logic       RXC,
  input  logic       arst,
  input  logic       CRS,
  input  logic       RXD,
  output logic [7:0] fifo_din,
  output logic       fifo_wren,
  output logic       fifo_EOD_in,
  input  logic       fifo_full,
  output logic       rx_done,
  output logic [3:0] rx_status
);

  localparam logic [7:0]  MIN_PRE_C = 8'(MIN_PREAMBLE);
  localparam logic [10:0] MIN_FRM_C = 11'(MIN_FRAME);
  localparam logic [10:0] MAX_FRM_C = 11'(MAX_FRAME);

  typedef enum logic [1:0] {S_IDLE, S_PREAMBLE, S_BODY, S_DROP} state_e;

  state_e      state_q, state_d;
  logic        prev_q, prev_d;
  logic [7:0]  alt_cnt_q, alt_cnt_d;
  logic [2:0]  bit_cnt_q, bit_cnt_d;
  logic [10:0] byte_cnt_q, byte_cnt_d;
  logic [7:0]  sr_q, sr_d;
  logic [7:0]  hold_q, hold_d;
  logic        hold_vld_q, hold_vld_d;
  logic [7:0]  din_q, din_d;
  logic        wren_q, wren_d;
  logic        eod_q, eod_d;
  logic        done_q, done_d;
  logic [3:0]  status_q, status_d;

  logic [7:0]  byte_now;
  logic [10:0] byte_inc;
  logic        fcs_bad;

  assign byte_now = {sr_q[6:0], RXD};
  assign byte_inc = (byte_cnt_q == 11'h7FF) ? byte_cnt_q : byte_cnt_q + 11'd1;

`ifdef SNI_RX_FCS_CHECK_EN
  logic [31:0] crc_q, crc_d;

  always_comb begin
    crc_d = crc_q;
    if (state_q != S_BODY) begin
      crc_d = '1;
    end else if (CRS) begin
      crc_d = {crc_q[30:0], 1'b0} ^ ((crc_q[31] ^ RXD) ? 32'h04C1_1DB7 : 32'h0);
    end
  end

  always_ff @(posedge RXC or posedge arst) begin
    if (arst) crc_q <= '1;
    else      crc_q <= crc_d;
  end

  assign fcs_bad = (crc_q != 32'hC704_DD7B);
`else
  assign fcs_bad = 1'b0;
`endif

  always_comb begin
    // NOTE: every signal gets a default first so no path leaves a latch behind.
    state_d    = state_q;
    prev_d     = prev_q;
    alt_cnt_d  = alt_cnt_q;
    bit_cnt_d  = bit_cnt_q;
    byte_cnt_d = byte_cnt_q;
    sr_d       = sr_q;
    hold_d     = hold_q;
    hold_vld_d = hold_vld_q;
    din_d      = din_q;
    wren_d     = 1'b0;
    eod_d      = 1'b0;
    done_d     = 1'b0;
    status_d   = status_q;

    unique case (state_q)
      S_IDLE: begin
        if (CRS) begin
          state_d   = S_PREAMBLE;
          prev_d    = RXD;
          alt_cnt_d = '0;
        end
      end

      S_PREAMBLE: begin
        if (!CRS) begin
          state_d = S_IDLE;
        end else begin
          prev_d = RXD;
          if (RXD != prev_q) begin
            if (alt_cnt_q != 8'hFF) alt_cnt_d = alt_cnt_q + 8'd1;
          end else if (RXD && (alt_cnt_q >= MIN_PRE_C)) begin
            state_d    = S_BODY;
            bit_cnt_d  = '0;
            byte_cnt_d = '0;
            sr_d       = '0;
            hold_vld_d = 1'b0;
          end else begin
            alt_cnt_d = '0;
          end
        end
      end

      S_BODY: begin
        if (!CRS) begin
          // Frame end: flush the held byte as EOD; a partial byte is simply dropped.
          state_d    = S_IDLE;
          done_d     = 1'b1;
          hold_vld_d = 1'b0;
          status_d   = {fcs_bad, (byte_cnt_q > MAX_FRM_C), (byte_cnt_q < MIN_FRM_C),
                        (bit_cnt_q != 3'd0)};
          if (hold_vld_q) begin
            if (fifo_full) begin
              status_d[2] = 1'b1;
            end else begin
              wren_d = 1'b1;
              eod_d  = 1'b1;
              din_d  = hold_q;
            end
          end
        end else begin
          sr_d      = byte_now;
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) begin
            byte_cnt_d = byte_inc;
            // Past MAX_FRAME the hold register freezes on byte MAX_FRAME for the EOD.
            if (byte_inc <= MAX_FRM_C) begin
              hold_d     = byte_now;
              hold_vld_d = 1'b1;
              if (hold_vld_q) begin
                if (fifo_full) begin
                  state_d    = S_DROP;
                  hold_vld_d = 1'b0;
                end else begin
                  wren_d = 1'b1;
                  din_d  = hold_q;
                end
              end
            end
          end
        end
      end

      S_DROP: begin
        if (!CRS) begin
          state_d  = S_IDLE;
          done_d   = 1'b1;
          status_d = 4'b0100;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge RXC or posedge arst) begin
    // NOTE: state registers use non-blocking assignments so all flops update together.
    if (arst) begin
      state_q    <= S_IDLE;
      prev_q     <= 1'b0;
      alt_cnt_q  <= '0;
      bit_cnt_q  <= '0;
      byte_cnt_q <= '0;
      sr_q       <= '0;
      hold_q     <= '0;
      hold_vld_q <= 1'b0;
      din_q      <= '0;
      wren_q     <= 1'b0;
      eod_q      <= 1'b0;
      done_q     <= 1'b0;
      status_q   <= '0;
    end else begin
      state_q    <= state_d;
      prev_q     <= prev_d;
      alt_cnt_q  <= alt_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      byte_cnt_q <= byte_cnt_d;
      sr_q       <= sr_d;
      hold_q     <= hold_d;
      hold_vld_q <= hold_vld_d;
      din_q      <= din_d;
      wren_q     <= wren_d;
      eod_q      <= eod_d;
      done_q     <= done_d;
      status_q   <= status_d;
    end
  end

  assign fifo_din    = din_q;
  assign fifo_wren   = wren_q;
  assign fifo_EOD_in = eod_q;
  assign rx_done     = done_q;
  assign rx_status   = status_q;

endmodule

// File: tb/tb_sni_rx_deframer.sv
// Self-checking bench for sni_rx_deframer: directed frames, expected FIFO writes and
// status pushed to scoreboards at stimulus time and compared when the DUT emits them.
module tb_sni_rx_deframer;

  localparam int          MIN_PREAMBLE = 16;
  localparam int          MIN_FRAME    = 64;
  localparam int          MAX_FRAME    = 1518;
  localparam logic [31:0] RESIDUE      = 32'hC704_DD7B;

  typedef struct packed {
    logic [7:0] data;
    logic       eod;
  } wr_t;

  logic       RXC = 1'b0;
  logic       arst;
  logic       CRS;
  logic       RXD;
  logic       fifo_full;
  logic [7:0] fifo_din;
  logic       fifo_wren;
  logic       fifo_EOD_in;
  logic       rx_done;
  logic [3:0] rx_status;

  int n_vec    = 0;
  int n_err    = 0;
  int wr_cnt   = 0;
  int done_cnt = 0;

  wr_t        wq[$];
  logic [3:0] sq[$];
  logic [7:0] frm [0:2047];

  sni_rx_deframer dut (
    .RXC        (RXC),
    .arst       (arst),
    .CRS        (CRS),
    .RXD        (RXD),
    .fifo_din   (fifo_din),
    .fifo_wren  (fifo_wren),
    .fifo_EOD_in(fifo_EOD_in),
    .fifo_full  (fifo_full),
    .rx_done    (rx_done),
    .rx_status  (rx_status)
  );

  always #5 RXC = ~RXC;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] crc_step(input logic [31:0] c, input logic b);
    return {c[30:0], 1'b0} ^ ((c[31] ^ b) ? 32'h04C1_1DB7 : 32'h0);
  endfunction

  // Output monitor: pops the scoreboards whenever the DUT writes or finishes a frame.
  always @(negedge RXC) begin
    wr_t        e;
    logic [3:0] s;
    if (fifo_wren) begin
      wr_cnt++;
      check("wr_expected", 32'(wq.size() != 0), 32'd1);
      if (wq.size() != 0) begin
        e = wq.pop_front();
        check("wr_data", 32'(fifo_din), 32'(e.data));
        check("wr_eod", 32'(fifo_EOD_in), 32'(e.eod));
      end
    end
    if (rx_done) begin
      done_cnt++;
      check("done_expected", 32'(sq.size() != 0), 32'd1);
      if (sq.size() != 0) begin
        s = sq.pop_front();
        check("rx_status", 32'(rx_status), 32'(s));
      end
    end
  end

  task automatic drive(input logic crs, input logic b);
    CRS = crs;
    RXD = b;
    @(negedge RXC);
  endtask

  task automatic fill_seq();
    for (int i = 0; i < 2048; i++) frm[i] = 8'(i);
  endtask

  // full_at > 0 raises fifo_full before body byte index full_at.
  task automatic send_frame(input string tag, input int n_alt, input int nbytes,
                            input int extra, input int full_at);
    logic [31:0] crc;
    logic        ovf, sfd, fcs_bad, seen;
    logic [3:0]  exp_st;
    int          nw, w0, d0;

    sfd = (n_alt >= MIN_PREAMBLE);
    ovf = (full_at > 0);
    nw  = (nbytes > MAX_FRAME) ? MAX_FRAME : nbytes;
    if (ovf)  nw = full_at - 1;
    if (!sfd) nw = 0;
    for (int i = 0; i < nw; i++) wq.push_back(wr_t'{frm[i], (!ovf && i == nw - 1)});

    crc = 32'hFFFF_FFFF;
    for (int i = 0; i < nbytes; i++)
      for (int b = 7; b >= 0; b--) crc = crc_step(crc, frm[i][b]);
    for (int k = 0; k < extra; k++) crc = crc_step(crc, (k % 2) == 0);
`ifdef SNI_RX_FCS_CHECK_EN
    fcs_bad = (crc != RESIDUE);
`else
    fcs_bad = 1'b0;
`endif
    exp_st = ovf ? 4'b0100 : {fcs_bad, (nbytes > MAX_FRAME), (nbytes < MIN_FRAME), (extra != 0)};
    if (sfd) sq.push_back(exp_st);

    w0 = wr_cnt;
    d0 = done_cnt;
    for (int i = 0; i < n_alt; i++) drive(1'b1, (i % 2) == 0);
    drive(1'b1, 1'b1);
    drive(1'b1, 1'b1);
    for (int i = 0; i < nbytes; i++) begin
      if (ovf && i == full_at) fifo_full = 1'b1;
      for (int b = 7; b >= 0; b--) drive(1'b1, frm[i][b]);
    end
    for (int k = 0; k < extra; k++) drive(1'b1, (k % 2) == 0);
    drive(1'b0, 1'b0);

    seen = 1'b0;
    repeat (40) begin
      @(posedge RXC);
      if (done_cnt != d0) begin
        seen = 1'b1;
        break;
      end
    end
    @(negedge RXC);
    fifo_full = 1'b0;
    check({tag, "_done_seen"}, 32'(seen), 32'(sfd));
    check({tag, "_n_writes"}, 32'(wr_cnt - w0), 32'(nw));
    check({tag, "_wr_left"}, 32'(wq.size()), 32'd0);
    check({tag, "_st_left"}, 32'(sq.size()), 32'd0);
    wq.delete();
    sq.delete();
    repeat (4) @(negedge RXC);
  endtask

  initial begin
    logic [31:0] c;
    int          w0, d0;

    arst      = 1'b1;
    CRS       = 1'b0;
    RXD       = 1'b0;
    fifo_full = 1'b0;
    repeat (3) @(negedge RXC);
    check("rst_din", 32'(fifo_din), 32'd0);
    check("rst_wren", 32'(fifo_wren), 32'd0);
    check("rst_eod", 32'(fifo_EOD_in), 32'd0);
    check("rst_done", 32'(rx_done), 32'd0);
    check("rst_status", 32'(rx_status), 32'd0);
    arst = 1'b0;
    repeat (2) @(negedge RXC);

    fill_seq();
    send_frame("basic64", 64, 64, 0, 0);
    send_frame("dribble", 64, 64, 3, 0);
    send_frame("runt10", 64, 10, 0, 0);
    send_frame("ovf20", 64, 64, 0, 20);
    send_frame("short_pre", 8, 3, 0, 0);
    send_frame("after_short", 64, 64, 0, 0);
    send_frame("zero_bytes", 64, 0, 5, 0);

    // Reset mid-frame: byte 0 held and a partial byte in flight must vanish silently.
    w0 = wr_cnt;
    d0 = done_cnt;
    for (int i = 0; i < 64; i++) drive(1'b1, (i % 2) == 0);
    drive(1'b1, 1'b1);
    drive(1'b1, 1'b1);
    for (int i = 0; i < 12; i++) drive(1'b1, 1'b0);
    arst = 1'b1;
    @(negedge RXC);
    check("midrst_wren", 32'(fifo_wren), 32'd0);
    check("midrst_done", 32'(rx_done), 32'd0);
    arst = 1'b0;
    drive(1'b0, 1'b0);
    repeat (20) @(negedge RXC);
    check("midrst_no_writes", 32'(wr_cnt - w0), 32'd0);
    check("midrst_no_done", 32'(done_cnt - d0), 32'd0);

    send_frame("long1520", 20, 1520, 0, 0);
    send_frame("max1518", 20, 1518, 0, 0);

    for (int i = 0; i < 60; i++) frm[i] = 8'(i * 7 + 3);
    c = 32'hFFFF_FFFF;
    for (int i = 0; i < 60; i++)
      for (int b = 7; b >= 0; b--) c = crc_step(c, frm[i][b]);
    c = ~c;
    frm[60] = c[31:24];
    frm[61] = c[23:16];
    frm[62] = c[15:8];
    frm[63] = c[7:0];
    send_frame("fcs_good", 64, 64, 0, 0);
    frm[10][3] = ~frm[10][3];
    send_frame("fcs_bad", 64, 64, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation exceeded its time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
